// File: rtl/spcore_pkg.sv
// rtl/spcore_pkg.sv - shared opcodes, write-back encodings, FSM states and instruction fields for spcore
package spcore_pkg;

    localparam logic [3:0] OP_ALU0 = 4'h0;
    localparam logic [3:0] OP_ALU1 = 4'h1;
    localparam logic [3:0] OP_ALU2 = 4'h2;
    localparam logic [3:0] OP_ALU3 = 4'h3;
    localparam logic [3:0] OP_ALU4 = 4'h4;
    localparam logic [3:0] OP_ALU5 = 4'h5;
    localparam logic [3:0] OP_ALU6 = 4'h6;
    localparam logic [3:0] OP_ALU7 = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BRP  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_NOP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] S2_IMM = 2'b00;
    localparam logic [1:0] S2_MEM = 2'b01;
    localparam logic [1:0] S2_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int X_MSB  = 27;
    localparam int X_LSB  = 24;
    localparam int Y_MSB  = 23;
    localparam int Y_LSB  = 20;
    localparam int Z_MSB  = 19;
    localparam int Z_LSB  = 16;
    localparam int I_MSB  = 15;
    localparam int I_LSB  = 0;

endpackage

// File: rtl/spcore_ctrl_if.sv
// rtl/spcore_ctrl_if.sv - sequencer-facing bundle: instruction fetch, data-memory handshake and core controls
interface spcore_ctrl_if #(parameter int PC_W = 8);
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            dmem_req;
    logic            dmem_ack;
    logic            P;
    logic [3:0]      x;
    logic [3:0]      y;
    logic [3:0]      z;
    logic [15:0]     I;
    logic [3:0]      aluc;
    logic [1:0]      s2;
    logic            reg_we;
    logic            en;
    logic            busy;
    logic            halted;

    modport master (
        input  start, imem_data, dmem_ack, P,
        output imem_addr, dmem_req, x, y, z, I, aluc, s2, reg_we, en, busy, halted
    );

    modport slave (
        output start, imem_data, dmem_ack, P,
        input  imem_addr, dmem_req, x, y, z, I, aluc, s2, reg_we, en, busy, halted
    );
endinterface

// File: rtl/spcore_decode.sv
// rtl/spcore_decode.sv - combinational opcode decode into ALU control, write-back select and class flags
module spcore_decode
    import spcore_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] z_field,
    output logic [3:0] aluc,
    output logic [1:0] s2,
    output logic       is_write,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_halt
);
    always_comb begin
        aluc      = 4'h0;
        s2        = S2_IMM;
        is_write  = 1'b0;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_halt   = 1'b0;
        case (op)
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3,
            OP_ALU4, OP_ALU5, OP_ALU6, OP_ALU7: begin
                aluc     = {1'b0, op[2:0]};
                s2       = S2_ALU;
                is_write = 1'b1;
            end
            OP_LDI: begin
                s2       = S2_IMM;
                is_write = 1'b1;
            end
            OP_LD: begin
                s2       = S2_MEM;
                is_write = 1'b1;
                is_mem   = 1'b1;
            end
            OP_ST: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            // BRP forwards z so the core's ALU computes the predicate it tests
            OP_BRP: begin
                aluc      = z_field;
                is_branch = 1'b1;
            end
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
            OP_NOP:  ;
            default: ;
        endcase
    end
endmodule

// File: rtl/spcore_ctrl.sv
// rtl/spcore_ctrl.sv - instruction sequencer: fetch/decode/exec FSM, PC, IR and data-memory handshake
module spcore_ctrl
    import spcore_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    spcore_ctrl_if.master   bus
);
    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [31:0]     ir;

    logic [3:0] dec_aluc;
    logic [1:0] dec_s2;
    logic       is_write, is_mem, is_store, is_branch, is_jump, is_halt;

    logic [3:0] aluc_c;
    logic [1:0] s2_c;
    logic       reg_we_c, dmem_req_c, en_c, busy_c, halted_c;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;

    assign pc_inc = pc + PC_W'(1);
    assign target = ir[PC_W-1:0];

    spcore_decode u_decode (
        .op        (ir[OP_MSB:OP_LSB]),
        .z_field   (ir[Z_MSB:Z_LSB]),
        .aluc      (dec_aluc),
        .s2        (dec_s2),
        .is_write  (is_write),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_halt   (is_halt)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            ir <= '0;
        end else begin
            pc <= pc_nx;
            if (state == ST_DECODE) ir <= bus.imem_data;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        aluc_c     = 4'h0;
        s2_c       = S2_IMM;
        reg_we_c   = 1'b0;
        dmem_req_c = 1'b0;
        en_c       = 1'b0;
        busy_c     = 1'b1;
        halted_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_nx = ST_FETCH;
                    pc_nx    = '0;
                end
            end
            ST_FETCH:  state_nx = ST_DECODE;
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                aluc_c   = dec_aluc;
                s2_c     = dec_s2;
                reg_we_c = is_write & ~is_mem;
                if (is_mem) begin
                    state_nx = ST_MEM;
                end else if (is_halt) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_FETCH;
                    pc_nx    = ((is_branch && bus.P) || is_jump) ? target : pc_inc;
                end
            end
            // Loads write back in the ack cycle itself; the PC advances on the same edge
            ST_MEM: begin
                aluc_c     = dec_aluc;
                s2_c       = dec_s2;
                dmem_req_c = 1'b1;
                en_c       = is_store;
                if (bus.dmem_ack) begin
                    reg_we_c = is_write;
                    state_nx = ST_FETCH;
                    pc_nx    = pc_inc;
                end
            end
            ST_HALT: begin
                busy_c   = 1'b0;
                halted_c = 1'b1;
                if (bus.start) begin
                    state_nx = ST_FETCH;
                    pc_nx    = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.imem_addr = pc;
    assign bus.x         = ir[X_MSB:X_LSB];
    assign bus.y         = ir[Y_MSB:Y_LSB];
    assign bus.z         = ir[Z_MSB:Z_LSB];
    assign bus.I         = ir[I_MSB:I_LSB];
    assign bus.aluc      = aluc_c;
    assign bus.s2        = s2_c;
    // A reset arriving alongside an ack must not let the load commit
    assign bus.reg_we    = reg_we_c & ~reset;
    assign bus.dmem_req  = dmem_req_c;
    assign bus.en        = en_c;
    assign bus.busy      = busy_c;
    assign bus.halted    = halted_c;
endmodule

// File: tb/tb_spcore_ctrl.sv
// tb/tb_spcore_ctrl.sv - self-checking bench for spcore_ctrl: directed vector table, corner sequences, random programs
module tb_spcore_ctrl;
    logic clk;
    logic reset;
    int   passed;
    int   total;
    logic [31:0] mem [0:255];

    spcore_ctrl_if #(.PC_W(8)) bus();

    spcore_ctrl #(.PC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    typedef struct {
        logic        restart;
        logic [7:0]  pc;
        logic [31:0] w;
        logic        p;
        int          n_ack;
        logic        start_mid;
        logic        exp_we;
        logic [1:0]  exp_s2;
        logic [3:0]  exp_aluc;
        logic        exp_mem;
        logic        exp_store;
        logic        exp_halt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input logic restart, input logic [7:0] pc, input logic [31:0] w, input logic p,
                       input int n_ack, input logic start_mid, input logic we, input logic [1:0] s2,
                       input logic [3:0] aluc, input logic is_mem, input logic is_st, input logic is_halt);
        vec_t v;
        v.restart = restart; v.pc = pc; v.w = w; v.p = p; v.n_ack = n_ack; v.start_mid = start_mid;
        v.exp_we = we; v.exp_s2 = s2; v.exp_aluc = aluc; v.exp_mem = is_mem; v.exp_store = is_st;
        v.exp_halt = is_halt;
        tbl.push_back(v);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
    endtask

    // Precondition: the DUT is in FETCH at the next falling edge.
    task automatic run_instr(input logic [7:0] pc, input logic [31:0] w, input logic p, input int n_ack,
                             input logic start_mid, input logic stray, input logic exp_we,
                             input logic [1:0] exp_s2, input logic [3:0] exp_aluc, input logic exp_mem,
                             input logic exp_store, input logic exp_halt);
        @(negedge clk);
        mem[pc] = w; bus.P = p; bus.dmem_ack = stray; bus.start = 1'b0;
        #1;
        chk("fetch_busy", bus.busy, 1);
        chk("fetch_addr", bus.imem_addr, pc);
        chk("fetch_we", bus.reg_we, 0);
        chk("fetch_req", bus.dmem_req, 0);
        @(negedge clk);
        bus.start = start_mid; bus.dmem_ack = stray;
        #1;
        chk("decode_we", bus.reg_we, 0);
        chk("decode_busy", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b0; bus.dmem_ack = stray;
        #1;
        chk("exec_we", bus.reg_we, exp_we & ~exp_mem);
        chk("exec_s2", bus.s2, exp_s2);
        chk("exec_aluc", bus.aluc, exp_aluc);
        chk("exec_x", bus.x, w[27:24]);
        chk("exec_i", bus.I, w[15:0]);
        chk("exec_req", bus.dmem_req, 0);
        if (exp_mem) begin
            for (int k = 1; k <= n_ack; k++) begin
                @(negedge clk);
                bus.dmem_ack = (k == n_ack);
                #1;
                chk("mem_req", bus.dmem_req, 1);
                chk("mem_en", bus.en, exp_store);
                chk("mem_we", bus.reg_we, (!exp_store && k == n_ack));
                if (k == n_ack && !exp_store) chk("mem_s2", bus.s2, 2'b01);
            end
        end
        if (exp_halt) begin
            @(negedge clk);
            bus.dmem_ack = 1'b0;
            #1;
            chk("halt_halted", bus.halted, 1);
            chk("halt_busy", bus.busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rpc;
        logic [3:0]  op;
        logic [31:0] r, w;
        logic        p, we, is_mem, is_st, is_halt;
        logic [1:0]  s2;
        logic [3:0]  aluc;
        int          n;

        passed = 0; total = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1; bus.start = 1'b0; bus.dmem_ack = 1'b0; bus.P = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_en", bus.en, 0);
        chk("rst_we", bus.reg_we, 0);
        chk("rst_aluc", bus.aluc, 0);
        chk("rst_s2", bus.s2, 0);
        chk("rst_xyz", {bus.x, bus.y, bus.z}, 0);
        chk("rst_i", bus.I, 0);

        // reset beats a simultaneous start
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        #1;
        chk("rst_start_busy", bus.busy, 0);

        //   rst pc     word          P n  smid we s2 aluc mem st halt
        add(1, 8'h00, 32'h8100_1234, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0);
        add(0, 8'h01, 32'h3211_0000, 0, 0, 0, 1, 2, 4'h3, 0, 0, 0);
        add(0, 8'h02, 32'h9300_0000, 0, 3, 0, 1, 1, 4'h0, 1, 0, 0);
        add(0, 8'h03, 32'hA040_0000, 0, 1, 0, 0, 0, 4'h0, 1, 1, 0);
        add(0, 8'h04, 32'hD000_0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 8'h05, 32'hB005_0020, 1, 0, 0, 0, 0, 4'h5, 0, 0, 0);
        add(0, 8'h20, 32'hC000_0005, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 8'h05, 32'hB002_0020, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0);
        add(0, 8'h06, 32'hC000_0010, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 8'h10, 32'hC000_00FF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 8'hFF, 32'hE000_0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 8'h00, 32'hF000_0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        add(1, 8'h00, 32'h7456_0000, 0, 0, 1, 1, 2, 4'h7, 0, 0, 0);
        add(0, 8'h01, 32'h9500_0000, 0, 1, 0, 1, 1, 4'h0, 1, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].restart) do_start();
            run_instr(tbl[i].pc, tbl[i].w, tbl[i].p, tbl[i].n_ack, tbl[i].start_mid, 1'b0,
                      tbl[i].exp_we, tbl[i].exp_s2, tbl[i].exp_aluc, tbl[i].exp_mem,
                      tbl[i].exp_store, tbl[i].exp_halt);
        end

        // reset while a store is waiting for its ack
        @(negedge clk);
        mem[2] = 32'hA000_0000; bus.dmem_ack = 1'b0;
        #1;
        chk("rst_st_fetch_addr", bus.imem_addr, 2);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_st_req", bus.dmem_req, 1);
        chk("rst_st_en", bus.en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_st_idle_busy", bus.busy, 0);
        chk("rst_st_idle_req", bus.dmem_req, 0);
        chk("rst_st_idle_en", bus.en, 0);
        chk("rst_st_idle_we", bus.reg_we, 0);
        chk("rst_st_idle_addr", bus.imem_addr, 0);

        // random programs against the instruction-level reference model
        rpc = 8'h00;
        do_start();
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            r  = $urandom;
            w  = {op, r[27:0]};
            p  = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            we      = (op <= 4'h9);
            is_mem  = (op == 4'h9) || (op == 4'hA);
            is_st   = (op == 4'hA);
            is_halt = (op == 4'hF);
            s2      = (op < 4'h8) ? 2'b10 : (op == 4'h9) ? 2'b01 : 2'b00;
            aluc    = (op < 4'h8) ? op : (op == 4'hB) ? w[19:16] : 4'h0;
            run_instr(rpc, w, p, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      we, s2, aluc, is_mem, is_st, is_halt);
            if (is_halt) begin
                do_start();
                rpc = 8'h00;
            end else if (op == 4'hC || (op == 4'hB && p)) begin
                rpc = w[7:0];
            end else begin
                rpc = rpc + 8'd1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spcore_ctrl.md
# spcore_ctrl

Instruction sequencer for the single-processor core (`spcore`). It fetches 32-bit instruction words from a synchronous instruction memory and decodes them into the core's register-select, immediate, ALU-control, write-back-mux and register-write signals. It performs the data-memory request/acknowledge handshake for loads and stores, and resolves conditional branches from the core's predicate output `P`. It sits between the instruction memory and `spcore`, one instance per core.

## Interface
Parameters:
- `PC_W`, 8, program-counter width; instruction memory depth is 2^PC_W words.

Ports:
- `clk`  in  1  clock. Everything is rising-edge.
- `reset`  in  1  **One clock; reset is synchronous and active-high.**
- `start`  in  1  pulse that begins execution at PC 0. Sampled only in IDLE or HALT.
- `imem_addr`  out  PC_W  instruction address. Memory returns data one cycle later.
- `imem_data`  in  32  instruction word.
- `dmem_req`  out  1  data-memory request. Held until `dmem_ack`.
- `dmem_ack`  in  1  one-cycle completion strobe.
- `P`  in  1  predicate from the core.
- `x`, `y`, `z`  out  4  register selects. The core writes register `x`.
- `I`  out  16  immediate.
- `aluc`  out  4  ALU control.
- `s2`  out  2  write-back mux select: 00 = `I`, 01 = `data_in`, 10 = ALU.
- `reg_we`  out  1  register-file write enable.
- `en`  out  1  data-memory write enable. Qualifies `dmem_req` for stores.
- `busy`  out  1  high in any state other than IDLE or HALT.
- `halted`  out  1  high in HALT.

## Operation
- **Instruction word fields:** [31:28] op, [27:24] x, [23:20] y, [19:16] z, [15:0] I. The IR latches the word in DECODE. `x`, `y`, `z` and `I` are driven from the IR.
- **Opcodes:**
  - 0x0–0x7 ALU: `aluc` = {0, op[2:0]}, `s2` = 10, `reg_we` in EXEC.
  - 0x8 LDI: `s2` = 00, `reg_we` in EXEC.
  - 0x9 LD: MEM state with `en` = 0. `reg_we` and `s2` = 01 in the `dmem_ack` cycle.
  - 0xA ST: MEM state with `en` = 1. No register write.
  - 0xB BRP: `aluc` = z field. If `P` = 1 in EXEC, PC ← I[PC_W-1:0], otherwise PC ← PC+1.
  - 0xC JMP: PC ← I[PC_W-1:0].
  - 0xD/0xE NOP.
  - 0xF HALT.
- **FSM states:** IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- **Transitions:**
  - IDLE → FETCH on `start`.
  - FETCH → DECODE.
  - DECODE → EXEC.
  - EXEC → MEM for LD/ST.
  - EXEC → HALT for op 0xF.
  - EXEC → FETCH otherwise.
  - MEM → FETCH on `dmem_ack`; MEM stays in MEM while `dmem_ack` is low.
  - HALT → FETCH on `start`, with PC reset to 0.
- **PC update:** occurs on the EXEC exit edge, or on the `dmem_ack` edge for LD/ST. The increment wraps modulo 2^PC_W (PC 2^PC_W−1 → 0).
- **Strobe discipline:** `reg_we` is high for exactly one cycle per writing instruction and never outside EXEC/MEM.
- **`start` handling:** `start` while `busy` is ignored.
- **Stray acknowledge:** `dmem_ack` outside MEM is ignored.

## Timing
- **Reset values:**
  - State IDLE.
  - PC = 0, IR = 0.
  - `imem_addr` = 0.
  - `dmem_req`, `en`, `reg_we`, `busy`, `halted` = 0.
  - `aluc` = 0, `s2` = 00; `x`, `y`, `z` = 0, `I` = 0.
- **Reset mid-operation:** returns to IDLE on the next edge. `dmem_req` drops immediately, with no wait for `dmem_ack`. No register write is issued.
- **Instruction latency:**
  - ALU, LDI, BRP, JMP, NOP: 3 cycles (FETCH, DECODE, EXEC).
  - LD/ST: 3 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the `dmem_ack` cycle.
- **`imem_addr`:** equals PC during FETCH. `imem_data` is captured at the DECODE edge.
- **`P` sampling:** `P` is combinational from the core and is sampled at the EXEC edge.
- **Data-memory handshake:** `dmem_req` rises on entry to MEM and is held with a stable `en`. It falls on the cycle after `dmem_ack` is sampled high. An ack in the first MEM cycle is legal (N = 1).
- **Simultaneous `reset` and `start`:** reset wins.

## Structure
- **Shared package `spcore_pkg`:**
  - opcode localparams (OP_ALU0..7, OP_LDI, OP_LD, OP_ST, OP_BRP, OP_JMP, OP_NOP, OP_HALT);
  - `s2` encodings (S2_IMM, S2_MEM, S2_ALU);
  - FSM state encoding;
  - instruction field bit positions.
- **Sub-module `spcore_decode`:** combinational; maps IR → `aluc`, `s2`, is_write, is_mem, is_store, is_branch, is_jump, is_halt. The FSM and PC stay in `spcore_ctrl`.

## Test plan
- **Reset and start:** reset, then `start`. `imem_addr` = 0 in FETCH and `busy` = 1. Before `start`, all outputs are 0.
- **LDI then ALU:** LDI x=1 I=0x1234, then op 0x3 x=2 y=1 z=1. `reg_we` pulses in cycle 3 with `s2` = 00, `I` = 0x1234. It pulses again in cycle 6 with `s2` = 10, `aluc` = 0x3. `imem_addr` sequence is 0, 1, 2.
- **LD with wait:** LD with `dmem_ack` delayed 3 cycles. `dmem_req` is high for 3 cycles with `en` = 0. `reg_we` is high with `s2` = 01 only in the ack cycle. The next FETCH has `imem_addr` = PC+1.
- **Branch and jump:**
  - BRP at PC 5, I = 0x20, `P` = 1: next fetch is 0x20.
  - Same with `P` = 0: next fetch is 6.
  - JMP I = 0xFF at PC 0x10: next fetch is 0xFF. The following NOP at 0xFF wraps PC to 0x00.
- **HALT and restart:** `halted` = 1 and `busy` = 0. `start` in HALT resumes at PC 0. `start` pulsed while `busy` has no effect.
- **Reset mid-ST:** reset asserted during MEM with `dmem_req` high. The next cycle shows IDLE, `dmem_req` = 0 and `en` = 0, and no `reg_we`.
